ipbus_master_arbiter: RTL

IPBUS_MASTER_ARBITER -- requirements
Module: ipbus_master_arbiter

---
 rtl/ipbus_arb_pkg.sv | 28 ++
 rtl/rr_priority_select.sv | 29 ++
 rtl/ipbus_master_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ipbus_arb_pkg.sv
// Shared types and bus-packing offsets for the IPbus multi-master arbiter.
package ipbus_arb_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_MASTERS = 8;
  localparam int unsigned IDX_W       = $clog2(MAX_MASTERS);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  // Master -> slave bus: addr[65:34], wdata[33:2], strobe[1], write[0]
  localparam int unsigned OUT_W         = 66;
  localparam int unsigned OUT_ADDR_LSB  = 34;
  localparam int unsigned OUT_WDATA_LSB = 2;
  localparam int unsigned OUT_STROBE    = 1;
  localparam int unsigned OUT_WRITE     = 0;

  // Slave -> master bus: rdata[33:2], ack[1], err[0]
  localparam int unsigned IN_W         = 34;
  localparam int unsigned IN_RDATA_LSB = 2;
  localparam int unsigned IN_ACK       = 1;
  localparam int unsigned IN_ERR       = 0;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first set request at or after start_i, ascending with wrap.
module rr_priority_select
  import ipbus_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!valid_o && req_i[j] && (j == (int'(start_i) + i) % N)) begin
          grant_o[j] = 1'b1;
          idx_o      = IDX_W'(j);
          valid_o    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ipbus_master_arbiter.sv
// Round-robin arbiter letting several IPbus transactors share one slave bus,
// with a strobe watchdog that synthesises a bus error on unanswered cycles.
module ipbus_master_arbiter
  import ipbus_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_MASTERS-1:0]       m_req,
  output logic [N_MASTERS-1:0]       m_grant,
  input  logic [OUT_W*N_MASTERS-1:0] m_ipb_out,
  output logic [IN_W*N_MASTERS-1:0]  m_ipb_in,
  output logic [OUT_W-1:0]           s_ipb_out,
  input  logic [IN_W-1:0]            s_ipb_in,
  output logic [IDX_W-1:0]           owner,
  output logic                       busy,
  output logic [15:0]                timeout_cnt
);

  // Assert asynchronously, release two edges after rst_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  arb_state_e             state_q, state_d;
  logic [N_MASTERS-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       last_owner_q, last_owner_d;
  logic                   busy_q, busy_d;
  logic [15:0]            wd_q, wd_d;
  logic [15:0]            tcnt_q, tcnt_d;

  logic [IDX_W-1:0]       start_idx;
  logic [N_MASTERS-1:0]   win_grant;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_valid;

  assign start_idx = (last_owner_q == IDX_W'(N_MASTERS - 1)) ? '0 : last_owner_q + 1'b1;

  rr_priority_select #(
    .N (N_MASTERS)
  ) u_rr_sel (
    .req_i   (m_req),
    .start_i (start_idx),
    .grant_o (win_grant),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  logic             owner_req;
  logic [OUT_W-1:0] sel_out;
  logic             s_ack, s_err, slave_stb, fire;

  // grant_q is one-hot on the owner, so it doubles as the slice select.
  assign owner_req = |(m_req & grant_q);

  always_comb begin
    sel_out = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (grant_q[k]) sel_out = m_ipb_out[k*OUT_W +: OUT_W];
    end
  end

  assign s_ack = s_ipb_in[IN_ACK];
  assign s_err = s_ipb_in[IN_ERR];

  // A real response in the timeout cycle suppresses the synthesised error.
  assign fire = busy_q & owner_req & sel_out[OUT_STROBE] & ~s_ack & ~s_err &
                (wd_q == 16'(TIMEOUT - 1));
  assign slave_stb = busy_q & owner_req & sel_out[OUT_STROBE] & ~fire;

  always_comb begin
    s_ipb_out                              = '0;
    s_ipb_out[OUT_ADDR_LSB +: ADDR_W]      = sel_out[OUT_ADDR_LSB +: ADDR_W];
    s_ipb_out[OUT_WDATA_LSB +: DATA_W]     = sel_out[OUT_WDATA_LSB +: DATA_W];
    s_ipb_out[OUT_STROBE]                  = slave_stb;
    s_ipb_out[OUT_WRITE]                   = sel_out[OUT_WRITE];
  end

  always_comb begin
    m_ipb_in = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      m_ipb_in[k*IN_W + IN_RDATA_LSB +: DATA_W] = s_ipb_in[IN_RDATA_LSB +: DATA_W];
      m_ipb_in[k*IN_W + IN_ACK]                 = grant_q[k] & s_ack;
      m_ipb_in[k*IN_W + IN_ERR]                 = grant_q[k] & (s_err | fire);
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    busy_d       = busy_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          grant_d = win_grant;
          owner_d = win_idx;
          busy_d  = 1'b1;
          state_d = GRANTED;
        end
      end
      GRANTED: begin
        if (!owner_req) begin
          grant_d      = '0;
          busy_d       = 1'b0;
          last_owner_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wd_d   = (fire || !slave_stb || s_ack || s_err) ? 16'd0 : wd_q + 16'd1;
    tcnt_d = (fire && tcnt_q != 16'hFFFF) ? tcnt_q + 16'd1 : tcnt_q;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(N_MASTERS - 1);
      busy_q       <= 1'b0;
      wd_q         <= '0;
      tcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      busy_q       <= busy_d;
      wd_q         <= wd_d;
      tcnt_q       <= tcnt_d;
    end
  end

  assign m_grant     = grant_q;
  assign owner       = owner_q;
  assign busy        = busy_q;
  assign timeout_cnt = tcnt_q;

endmodule
